// File: rtl/mult_pkg.sv
// mult_pkg
//   Shared definitions for the shift_add_mult multiplier:
//     DEFAULT_WIDTH - default operand width in bits
//     state_e       - controller states (IDLE, RUN, DONE)
//     cnt_width()   - width of the iteration counter for a given operand width
package mult_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter must hold 0..WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if
//   Request/result bundle of the multiplier.
//     start        - one-cycle request, operands sampled on the same edge
//     multiplicand - operand M (WIDTH bits)
//     multiplier   - operand Q (WIDTH bits)
//     busy         - high while iterating
//     done         - one-cycle pulse, product valid in the same cycle
//     product      - 2*WIDTH-bit result, held until the next accepted start
//   master: the requester; slave: the multiplier.
interface shift_add_mult_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                 start;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/mult_iter_counter.sv
// mult_iter_counter
//   Iteration counter for the multiplier.
//     clk  - rising-edge clock
//     rst  - synchronous active-high reset (count -> 0)
//     clr  - clear count to 0 (has priority over en)
//     en   - advance count by one
//     last - high while count == WIDTH-1 (the final iteration)
module mult_iter_counter
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult
//   Sequential multiplier: one partial product per clock, WIDTH iterations,
//   result presented WIDTH+1 cycles after the accepting edge.
//     clk - rising-edge clock
//     rst - synchronous active-high reset
//     bus - shift_add_mult_if.slave (start/operands in, busy/done/product out)
//   Build option MULT_SIGNED_EN: two's complement operands and product using
//   radix-2 Booth recoding; otherwise unsigned shift-and-add. Ports and
//   timing are identical in both builds.
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_mult_if.slave       bus
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [WIDTH:0]       a_q, a_d;        // accumulator incl. carry/sign bit
  logic [WIDTH-1:0]     q_q, q_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic                 done_q, done_d;
`ifdef MULT_SIGNED_EN
  logic                 qp_q, qp_d;      // Booth q_prev bit
`endif

  logic                 accept;
  logic [WIDTH:0]       sum;
  logic                 cnt_clr, cnt_en, cnt_last;

  mult_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .last (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    product_d = product_q;
    done_d    = 1'b0;
`ifdef MULT_SIGNED_EN
    qp_d      = qp_q;
`endif
    accept    = 1'b0;
    sum       = a_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    case (state_q)
      IDLE: accept = bus.start;
      RUN: begin
        cnt_en = 1'b1;
`ifdef MULT_SIGNED_EN
        if ({q_q[0], qp_q} == 2'b10) begin
          sum = a_q - {m_q[WIDTH-1], m_q};
        end else if ({q_q[0], qp_q} == 2'b01) begin
          sum = a_q + {m_q[WIDTH-1], m_q};
        end
        // Arithmetic shift of {A,Q,q_prev}.
        a_d  = {sum[WIDTH], sum[WIDTH:1]};
        qp_d = q_q[0];
`else
        if (q_q[0]) begin
          sum = a_q + {1'b0, m_q};
        end
        // Carry lands in sum[WIDTH] and is shifted down into A.
        a_d = {1'b0, sum[WIDTH:1]};
`endif
        q_d = {sum[0], q_q[WIDTH-1:1]};
        if (cnt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        product_d = {a_q[WIDTH-1:0], q_q};
        done_d    = 1'b1;
        state_d   = IDLE;
        // Back-to-back request is taken on the same edge the result is posted.
        accept    = bus.start;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      m_d     = bus.multiplicand;
      q_d     = bus.multiplier;
      a_d     = '0;
`ifdef MULT_SIGNED_EN
      qp_d    = 1'b0;
`endif
      cnt_clr = 1'b1;
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
`ifdef MULT_SIGNED_EN
      qp_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      product_q <= product_d;
      done_q    <= done_d;
`ifdef MULT_SIGNED_EN
      qp_q      <= qp_d;
`endif
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule
